// File: rtl/mor1k_snoop_hub.sv
// Snoop hub for multi-core mor1k tiles: per-core write-address FIFOs drained by a round-robin
// arbiter into one broadcast snoop per cycle. Define MOR1K_SNOOP_SELF_EN to snoop the source core too.
module mor1k_snoop_hub #(
    parameter int CORE_NUM   = 4,
    parameter int AW         = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CORE_NUM*AW-1:0] dwb_adr_i,
    input  logic [CORE_NUM-1:0]    dwb_cyc_i,
    input  logic [CORE_NUM-1:0]    dwb_stb_i,
    input  logic [CORE_NUM-1:0]    dwb_we_i,
    input  logic [CORE_NUM-1:0]    dwb_ack_i,
    output logic [AW-1:0]          snoop_adr_o,
    output logic [CORE_NUM-1:0]    snoop_en_o,
    output logic [CORE_NUM-1:0]    stall_o,
    output logic [CORE_NUM-1:0]    ovf_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;

    logic [AW-1:0]       mem_q    [CORE_NUM][FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q [CORE_NUM];
    logic [PW-1:0]       wr_ptr_d [CORE_NUM];
    logic [PW-1:0]       rd_ptr_q [CORE_NUM];
    logic [PW-1:0]       rd_ptr_d [CORE_NUM];
    logic [CW-1:0]       count_q  [CORE_NUM];
    logic [CW-1:0]       count_d  [CORE_NUM];
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]       snoop_adr_q, snoop_adr_d;
    logic [CORE_NUM-1:0] snoop_en_q, snoop_en_d;
    logic [CORE_NUM-1:0] stall_q, stall_d;
    logic [CORE_NUM-1:0] ovf_q, ovf_d;

    logic [CORE_NUM-1:0] commit, full, push, pop;
    logic                grant_vld;
    logic [IW-1:0]       grant_idx;
    logic [IW:0]         cand;

    // Round-robin search: first non-empty FIFO at or above rr_ptr, wrapping at CORE_NUM.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < CORE_NUM; k++) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(CORE_NUM)) cand = cand - (IW+1)'(CORE_NUM);
            if (!grant_vld && count_q[cand[IW-1:0]] != '0) begin
                grant_vld = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) rr_ptr_d = (grant_idx == IW'(CORE_NUM-1)) ? '0 : grant_idx + 1'b1;
    end

    // A full FIFO still accepts a push when its head is popped in the same cycle.
    always_comb begin
        for (int i = 0; i < CORE_NUM; i++) begin
            commit[i]   = dwb_cyc_i[i] & dwb_stb_i[i] & dwb_we_i[i] & dwb_ack_i[i];
            pop[i]      = grant_vld && (grant_idx == IW'(i));
            full[i]     = (count_q[i] == CW'(FIFO_DEPTH));
            push[i]     = commit[i] && (!full[i] || pop[i]);
            ovf_d[i]    = ovf_q[i] | (commit[i] & full[i] & ~pop[i]);
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
            count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
            stall_d[i]  = (count_q[i] >= CW'(FIFO_DEPTH-1));
        end
    end

    always_comb begin
        snoop_adr_d = snoop_adr_q;
        snoop_en_d  = '0;
        if (grant_vld) begin
            snoop_adr_d = mem_q[grant_idx][rd_ptr_q[grant_idx]];
`ifdef MOR1K_SNOOP_SELF_EN
            snoop_en_d  = '1;
`else
            snoop_en_d  = ~(CORE_NUM'(1) << grant_idx);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            for (int i = 0; i < CORE_NUM; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            snoop_adr_q <= '0;
            snoop_en_q  <= '0;
            stall_q     <= '0;
            ovf_q       <= '0;
        end else begin
            for (int i = 0; i < CORE_NUM; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            snoop_adr_q <= snoop_adr_d;
            snoop_en_q  <= snoop_en_d;
            stall_q     <= stall_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: FIFO storage has no reset; zeroed counts make stale contents unreachable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CORE_NUM; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= dwb_adr_i[i*AW +: AW];
        end
    end

    assign snoop_adr_o = snoop_adr_q;
    assign snoop_en_o  = snoop_en_q;
    assign stall_o     = stall_q;
    assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_mor1k_snoop_hub.sv
// Self-checking bench for mor1k_snoop_hub: queue-based reference model compared every cycle,
// plus directed literal checks. Honours MOR1K_SNOOP_SELF_EN when defined.
`timescale 1ns/1ps
module tb_mor1k_snoop_hub;
    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

`ifdef MOR1K_SNOOP_SELF_EN
    localparam logic [N-1:0] EN_C0 = 4'b1111;
    localparam logic [N-1:0] EN_C1 = 4'b1111;
    localparam logic [N-1:0] EN_C2 = 4'b1111;
    localparam logic [N-1:0] EN_C3 = 4'b1111;
`else
    localparam logic [N-1:0] EN_C0 = 4'b1110;
    localparam logic [N-1:0] EN_C1 = 4'b1101;
    localparam logic [N-1:0] EN_C2 = 4'b1011;
    localparam logic [N-1:0] EN_C3 = 4'b0111;
`endif

    logic            clk;
    logic            rst;
    logic [AW-1:0]   adr [N];
    logic [N*AW-1:0] dwb_adr;
    logic [N-1:0]    cyc, stb, we, ack;
    logic [AW-1:0]   snoop_adr;
    logic [N-1:0]    snoop_en, stall, ovf;

    int              n_cmp;
    int              n_fail;
    bit              done;
    logic [AW-1:0]   log_q [$];

    always_comb begin
        dwb_adr = '0;
        for (int i = 0; i < N; i++) dwb_adr[i*AW +: AW] = adr[i];
    end

    mor1k_snoop_hub #(.CORE_NUM(N), .AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .dwb_adr_i   (dwb_adr),
        .dwb_cyc_i   (cyc),
        .dwb_stb_i   (stb),
        .dwb_we_i    (we),
        .dwb_ack_i   (ack),
        .snoop_adr_o (snoop_adr),
        .snoop_en_o  (snoop_en),
        .stall_o     (stall),
        .ovf_o       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] sel_mask(input int g);
`ifdef MOR1K_SNOOP_SELF_EN
        sel_mask = '1;
`else
        sel_mask = ~(N'(1) << g);
`endif
    endfunction

    // Reference model: one queue per core, a round-robin start index, one pop per edge.
    logic [AW-1:0] mq [N][$];
    int            m_rr;
    logic [AW-1:0] m_adr;
    logic [N-1:0]  m_en, m_stall, m_ovf;

    always @(posedge clk or negedge rst) begin : model
        int sz [N];
        int g;
        if (!rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr    <= 0;
            m_adr   <= '0;
            m_en    <= '0;
            m_stall <= '0;
            m_ovf   <= '0;
        end else begin
            for (int i = 0; i < N; i++) sz[i] = mq[i].size();
            for (int i = 0; i < N; i++) m_stall[i] <= (sz[i] >= DEPTH-1);
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && sz[(m_rr+k)%N] > 0) g = (m_rr+k)%N;
            m_en <= '0;
            if (g >= 0) begin
                m_adr <= mq[g].pop_front();
                m_en  <= sel_mask(g);
                m_rr  <= (g+1)%N;
            end
            for (int i = 0; i < N; i++) begin
                if (cyc[i] && stb[i] && we[i] && ack[i]) begin
                    if (sz[i] < DEPTH || g == i) mq[i].push_back(adr[i]);
                    else m_ovf[i] <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = '0; stb = '0; we = '0; ack = '0;
    endtask

    task automatic put(input int c, input logic [AW-1:0] a);
        adr[c] = a;
        cyc[c] = 1'b1; stb[c] = 1'b1; we[c] = 1'b1; ack[c] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic check_outs(input string name, input logic [AW-1:0] a, input logic [N-1:0] en);
        @(negedge clk);
        check({name, "_adr"}, snoop_adr, a);
        check({name, "_en"}, AW'(snoop_en), AW'(en));
    endtask

    initial begin
        rst = 1'b0; done = 1'b0; n_cmp = 0; n_fail = 0;
        cyc = '0; stb = '0; we = '0; ack = '0;
        for (int i = 0; i < N; i++) adr[i] = '0;
        fork
            begin : stim
                // Reset held while the bus toggles: nothing may come out.
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) put(i, $urandom());
                    @(negedge clk);
                    check("rst_en", AW'(snoop_en), '0);
                    check("rst_adr", snoop_adr, '0);
                    check("rst_stall", AW'(stall), '0);
                    check("rst_ovf", AW'(ovf), '0);
                    tick();
                end
                rst = 1'b1;
                put(1, 32'h100);
                tick();
                @(negedge clk);
                check("lat_n1_en", AW'(snoop_en), '0);
                tick();
                check_outs("lat_n2", 32'h100, EN_C1);
                tick();
                @(negedge clk);
                check("lat_n3_en", AW'(snoop_en), '0);

                // Round robin, then a late core 0 write behind pending core 3.
                do_reset();
                put(0, 32'h10); put(1, 32'h20); put(3, 32'h30);
                tick();
                put(0, 32'h11);
                tick();
                check_outs("rr0", 32'h10, EN_C0);
                tick();
                check_outs("rr1", 32'h20, EN_C1);
                tick();
                check_outs("rr3", 32'h30, EN_C3);
                tick();
                check_outs("rr0b", 32'h11, EN_C0);
                tick();
                check_outs("rr_idle", 32'h11, '0);

                // Reset while entries are queued discards them.
                do_reset();
                for (int i = 0; i < N; i++) put(i, AW'(32'h500 + i));
                tick();
                rst = 1'b0;
                @(negedge clk);
                check("midrst_en", AW'(snoop_en), '0);
                check("midrst_adr", snoop_adr, '0);
                tick();
                rst = 1'b1;
                log_q.delete();
                for (int c = 0; c < 6; c++) tick();
                check("midrst_nosnoop", AW'(log_q.size()), '0);

                // Core 2 back-pressure, full-with-pop and overflow while cores 3/0/1 hold grants.
                do_reset();
                log_q.delete();
                put(0, 32'h0C0); put(1, 32'h1C0); put(2, 32'h200); put(3, 32'h3C0);
                tick();
                put(0, 32'h0C1); put(1, 32'h1C1); put(3, 32'h3C1);
                tick();
                tick();
                for (int k = 0; k < 6; k++) begin
                    put(2, AW'(32'h201 + k));
                    @(negedge clk);
                    if (k == 1) begin
                        check("ov_first_adr", snoop_adr, 32'h200);
                        check("ov_first_en", AW'(snoop_en), AW'(EN_C2));
                    end
                    if (k == 3) check("ov_stall_lo", AW'(stall[2]), '0);
                    if (k == 4) begin
                        check("ov_stall_hi", AW'(stall[2]), 1);
                        check("ov_fullpop_ovf", AW'(ovf), '0);
                    end
                    if (k == 5) check("ov_pre_ovf", AW'(ovf), '0);
                    tick();
                end
                @(negedge clk);
                check("ov_set", AW'(ovf), AW'(4'b0100));
                for (int c = 0; c < 8; c++) tick();
                @(negedge clk);
                check("ov_sticky", AW'(ovf), AW'(4'b0100));
                check("ov_stall_clear", AW'(stall), '0);
                check("ov_total", AW'(log_q.size()), 12);
                begin
                    logic [AW-1:0] c2 [$];
                    foreach (log_q[j]) if (log_q[j][11:8] == 4'h2) c2.push_back(log_q[j]);
                    check("ov_c2_count", AW'(c2.size()), 6);
                    foreach (c2[j]) check("ov_c2_order", c2[j], AW'(32'h200 + j));
                end

                // Pointer wrap with non-committing bus noise in between.
                do_reset();
                log_q.delete();
                for (int k = 0; k < 3*DEPTH; k++) begin
                    put(1, AW'(k));
                    tick();
                    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; ack[2] = 1'b0;
                    cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b0; ack[3] = 1'b1;
                    tick();
                end
                for (int c = 0; c < 3; c++) tick();
                check("wrap_count", AW'(log_q.size()), 3*DEPTH);
                foreach (log_q[j]) check("wrap_order", log_q[j], AW'(j));

                // Source-bit handling on a plain core 0 write.
                do_reset();
                put(0, 32'h40);
                tick();
                tick();
                check_outs("self", 32'h40, EN_C0);
                tick();
                done = 1'b1;
            end
            begin : compare
                while (!done) begin
                    @(negedge clk);
                    check("m_snoop_adr", snoop_adr, m_adr);
                    check("m_snoop_en", AW'(snoop_en), AW'(m_en));
                    check("m_stall", AW'(stall), AW'(m_stall));
                    check("m_ovf", AW'(ovf), AW'(m_ovf));
                    if (snoop_en != '0) log_q.push_back(snoop_adr);
                end
            end
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mor1k_snoop_hub.md
# mor1k_snoop_hub

Coherence helper for multi-core mor1k tiles. It observes the data Wishbone master of each of CORE_NUM cores and queues every committed write address in a per-core FIFO. A round-robin arbiter drains the FIFOs and broadcasts one snoop per cycle to the other cores' `snoop_adr_i`/`snoop_en_i` inputs, so their data caches invalidate stale lines. It sits beside the per-core wrappers and generalises the single-core case, where snoop inputs are tied off or driven externally.

## Interface
- `CORE_NUM`, 4: number of cores observed and served; range 2..16.
- `AW`, 32: address width; word addresses as driven on `dwbm_adr_o` (`{2'b00, byte_adr[31:2]}`).
- `FIFO_DEPTH`, 4: entries per core FIFO; power of two, ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `dwb_adr_i`  in  CORE_NUM*AW  per-core data-bus word address; core i occupies `[i*AW +: AW]`.
- `dwb_cyc_i`, `dwb_stb_i`, `dwb_we_i`, `dwb_ack_i`  in  CORE_NUM each  per-core Wishbone qualifiers.
- `snoop_adr_o`  out  AW  broadcast word address, shared by all cores.
- `snoop_en_o`  out  CORE_NUM  per-core snoop strobe; bit i goes to core i `snoop_en_i`.
- `stall_o`  out  CORE_NUM  per-core back-pressure; OR into that core's `du_stall_i`.
- `ovf_o`  out  CORE_NUM  sticky per-core overflow flag.

## Operation
- Capture: core i commits a write when `dwb_cyc_i[i] & dwb_stb_i[i] & dwb_we_i[i] & dwb_ack_i[i]`. On commit, push `dwb_adr_i[i]` into FIFO i. Each registered-feedback burst beat is a separate commit.
- FIFO: one per core, `FIFO_DEPTH` entries. Read/write pointers are `log2(FIFO_DEPTH)` bits and wrap modulo depth. The count is `log2(FIFO_DEPTH)+1` bits.
- Arbiter: round-robin over the non-empty FIFOs.
  - At most one grant per cycle.
  - Search order starts at `rr_ptr` and proceeds upward, wrapping at CORE_NUM.
  - After granting core g, `rr_ptr <= (g+1) mod CORE_NUM`.
  - With no requests, `rr_ptr` holds.
- Broadcast: the granted FIFO head is popped.
  - Next cycle: `snoop_adr_o <= head` and `snoop_en_o <= ~(1<<g)`, so the source core is masked.
  - With no grant, `snoop_en_o <= 0` and `snoop_adr_o` holds its last value.
- Simultaneous push and pop on the same FIFO: both are performed and the count is unchanged. This applies when the FIFO is full: the push is accepted and no overflow occurs.
- Back-pressure: `stall_o[i]` is registered and is 1 while `count_i >= FIFO_DEPTH-1`. This leaves one slot for a write already in flight.
- Overflow: a push to a full FIFO with no same-cycle pop is dropped, and `ovf_o[i]` is set. Only reset clears it.
- Commits from several cores in the same cycle are all captured, each into its own FIFO.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - `snoop_adr_o`=0, `snoop_en_o`=0, `stall_o`=0, `ovf_o`=0;
  - all pointers and counts 0, `rr_ptr`=0.
- Reset mid-operation discards queued entries; no snoop is emitted for them.
- Latency: a commit in cycle N into an empty FIFO that wins arbitration gives `snoop_en_o` high in cycle N+2.
  - N+1: the entry is visible and the grant occurs.
  - N+2: registered broadcast.
- `snoop_en_o` pulses for exactly one cycle per entry. Throughput is one snoop per cycle across all cores.
- `stall_o` follows the count with one cycle of register delay.
- Worst-case wait for a queued entry is CORE_NUM−1 grants to other cores per FIFO position ahead of it.

## Configuration
- `MOR1K_SNOOP_SELF_EN` defined: `snoop_en_o` is all ones on every broadcast, so the source core also snoops its own writes. This is for debug and cache-consistency checking.
- `MOR1K_SNOOP_SELF_EN` undefined (default): the source bit is masked, `snoop_en_o = ~(1<<g)`.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0, toggle bus inputs.
  - Required: all outputs 0. After release, one write by core 1 to word 0x0000_0100 → `snoop_adr_o`=0x100 and `snoop_en_o`=4'b1101 two cycles after the ack.
- Round robin:
  - Stimulus: cores 0, 1 and 3 commit 0x10, 0x20, 0x30 in the same cycle.
  - Required: broadcasts on three consecutive cycles in order 0x10/1110, 0x20/1101, 0x30/0111. Then a new core 0 write is served after a pending core 3 write.
- Back-pressure and overflow, core 2, FIFO_DEPTH=4, no grants possible (other FIFOs kept busy):
  - Stimulus: four writes in four cycles, then a fifth.
  - Required: `stall_o[2]`=1 one cycle after the third push; the fifth write is dropped and `ovf_o[2]`=1 and stays 1.
- Full with simultaneous pop:
  - Stimulus: a full FIFO is granted in the same cycle as a new commit.
  - Required: the entry is accepted, `ovf_o` stays 0, and all five addresses appear in order.
- Pointer wrap:
  - Stimulus: 3×FIFO_DEPTH sequential writes 0x0..0xB from one core, spaced for draining.
  - Required: snoops appear in exact order with no loss or duplication.
- Macro:
  - Stimulus: with `MOR1K_SNOOP_SELF_EN` defined, core 0 writes 0x40.
  - Required: `snoop_en_o`=4'b1111.
